// File: rtl/wired_fooo_ex_pkg.sv
// Shared types for the FPU execution responder: issue-queue request and
// response bundles, exception flags, ROB id and the per-slot table entry.
package wired_fooo_ex_pkg;

    localparam int WIRED_FPU_SLOTS = 4;
    localparam int FPU_OP_W        = 4;
    localparam int FPU_MODE_W      = 1;
    localparam int ROB_RID_W       = 6;

    typedef logic [ROB_RID_W-1:0] rob_rid_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_excp_t;

    typedef struct packed {
        logic [FPU_OP_W-1:0]   op;
        logic [FPU_MODE_W-1:0] mode;
        logic [31:0]           r0;
        logic [31:0]           r1;
        logic [31:0]           r2;
        rob_rid_t              wid;
    } iq_fpu_req_t;

    typedef struct packed {
        rob_rid_t    wid;
        logic [31:0] result;
        fp_excp_t    fp_excp;
    } iq_fpu_resp_t;

    typedef struct packed {
        logic     busy;
        logic     kill;
        rob_rid_t wid;
    } fpu_slot_t;

endpackage

// File: rtl/wired_fifo.sv
// Small synchronous FIFO with registered storage and async active-low reset.
// Ports: push/wdata in, pop/rdata out, empty/full/count status.
module wired_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wired_fooo_ex_slot_alloc.sv
// Slot table (busy/kill/wid) with lowest-free-index allocation.
// Ports: alloc/alloc_wid, ret/ret_tag, flush in; sel, free_any, busy, ret_* out.
module wired_fooo_ex_slot_alloc
    import wired_fooo_ex_pkg::*;
#(
    parameter int SLOTS = WIRED_FPU_SLOTS,
    parameter int TAG_W = $clog2(SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  rob_rid_t         alloc_wid,
    input  logic             ret,
    input  logic [TAG_W-1:0] ret_tag,
    input  logic             flush,
    output logic             free_any,
    output logic [TAG_W-1:0] sel,
    output logic [SLOTS-1:0] busy,
    output logic             ret_busy,
    output logic             ret_kill,
    output rob_rid_t         ret_wid
);

    fpu_slot_t slot [SLOTS];

    always_comb begin
        sel      = '0;
        free_any = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            busy[i] = slot[i].busy;
            if (!free_any && !slot[i].busy) begin
                sel      = TAG_W'(i);
                free_any = 1'b1;
            end
        end
    end

    assign ret_busy = slot[ret_tag].busy;
    assign ret_kill = slot[ret_tag].kill;
    assign ret_wid  = slot[ret_tag].wid;

    // Alloc and return never hit the same slot: alloc picks a slot that
    // was free at cycle start, return only acts on a slot that was busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) slot[i] <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (flush) slot[i].kill <= slot[i].busy;
                if (alloc && sel == TAG_W'(i)) begin
                    slot[i].busy <= 1'b1;
                    slot[i].kill <= 1'b0;
                    slot[i].wid  <= alloc_wid;
                end
                if (ret && ret_tag == TAG_W'(i)) begin
                    slot[i].busy <= 1'b0;
                    slot[i].kill <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wired_fooo_ex.sv
// FPU execution responder: tags issue-queue ops for fpnew, maps returning
// tags back to ROB ids and queues results for the CDB. Supports flush/kill.
// Ports: ex_* issue side, core_* fpnew side, flush_i, idle_o.
module wired_fooo_ex
    import wired_fooo_ex_pkg::*;
#(
    parameter int SLOTS      = WIRED_FPU_SLOTS,
    parameter int TAG_W      = $clog2(SLOTS),
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  iq_fpu_req_t           ex_req_i,
    output logic                  ex_valid_o,
    input  logic                  ex_ready_i,
    output iq_fpu_resp_t          ex_resp_o,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    output logic [FPU_OP_W-1:0]   core_op_o,
    output logic [FPU_MODE_W-1:0] core_mode_o,
    output logic [31:0]           core_opa_o,
    output logic [31:0]           core_opb_o,
    output logic [31:0]           core_opc_o,
    output logic [TAG_W-1:0]      core_tag_o,
    input  logic                  core_valid_i,
    output logic                  core_ready_o,
    input  logic [31:0]           core_result_i,
    input  fp_excp_t              core_status_i,
    input  logic [TAG_W-1:0]      core_tag_i,
    input  logic                  flush_i,
    output logic                  idle_o
);

    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic             free_any;
    logic [SLOTS-1:0] busy;
    logic             ret_busy;
    logic             ret_kill;
    rob_rid_t         ret_wid;
    logic             alloc;
    logic             ret;
    logic             push;
    iq_fpu_resp_t     push_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CW-1:0]    fifo_count;
    logic             flush_q;
    logic             fifo_rst_n;

    assign ex_ready_o   = ~rst & free_any & core_ready_i & ~flush_i;
    assign core_valid_o = ~rst & ex_valid_i & free_any & ~flush_i;
    assign alloc        = ex_valid_i & ex_ready_o;

    assign core_op_o   = ex_req_i.op;
    assign core_mode_o = ex_req_i.mode;
    assign core_opa_o  = ex_req_i.r0;
    assign core_opb_o  = ex_req_i.r1;
    assign core_opc_o  = ex_req_i.r2;

    // Returns on a non-busy tag are protocol errors and are dropped.
    assign core_ready_o = ~fifo_full;
    assign ret          = core_valid_i & core_ready_o & ret_busy;
    assign push         = ret & ~ret_kill & ~flush_i;

    always_comb begin
        push_data         = '0;
        push_data.wid     = ret_wid;
        push_data.result  = core_result_i;
        push_data.fp_excp = core_status_i;
    end

    wired_fooo_ex_slot_alloc #(
        .SLOTS (SLOTS),
        .TAG_W (TAG_W)
    ) u_slots (
        .clk       (clk),
        .rst       (rst),
        .alloc     (alloc),
        .alloc_wid (ex_req_i.wid),
        .ret       (ret),
        .ret_tag   (core_tag_i),
        .flush     (flush_i),
        .free_any  (free_any),
        .sel       (core_tag_o),
        .busy      (busy),
        .ret_busy  (ret_busy),
        .ret_kill  (ret_kill),
        .ret_wid   (ret_wid)
    );

    // The FIFO is emptied the cycle after a flush by holding it in reset
    // from a registered flush. Nothing live can be pushed in that cycle:
    // every busy slot was just killed and no request was accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flush_q <= 1'b0;
        else     flush_q <= flush_i;
    end

    assign fifo_rst_n = ~rst & ~flush_q;

    wired_fifo #(
        .WIDTH ($bits(iq_fpu_resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (fifo_rst_n),
        .push  (push),
        .wdata (push_data),
        .pop   (ex_ready_i),
        .rdata (ex_resp_o),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign ex_valid_o = ~fifo_empty;
    assign idle_o     = ~|busy & (fifo_count == '0);

endmodule

// File: tb/tb_wired_fooo_ex.sv
// Directed bench for wired_fooo_ex: OOO return, exhaustion, backpressure,
// flush and async reset, with hand-computed expected values.
module tb_wired_fooo_ex;
    import wired_fooo_ex_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ex_valid_i;
    logic                  ex_ready_o;
    iq_fpu_req_t           ex_req_i;
    logic                  ex_valid_o;
    logic                  ex_ready_i;
    iq_fpu_resp_t          ex_resp_o;
    logic                  core_valid_o;
    logic                  core_ready_i;
    logic [FPU_OP_W-1:0]   core_op_o;
    logic [FPU_MODE_W-1:0] core_mode_o;
    logic [31:0]           core_opa_o;
    logic [31:0]           core_opb_o;
    logic [31:0]           core_opc_o;
    logic [1:0]            core_tag_o;
    logic                  core_valid_i;
    logic                  core_ready_o;
    logic [31:0]           core_result_i;
    fp_excp_t              core_status_i;
    logic [1:0]            core_tag_i;
    logic                  flush_i;
    logic                  idle_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wired_fooo_ex dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid_i    (ex_valid_i),
        .ex_ready_o    (ex_ready_o),
        .ex_req_i      (ex_req_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .ex_resp_o     (ex_resp_o),
        .core_valid_o  (core_valid_o),
        .core_ready_i  (core_ready_i),
        .core_op_o     (core_op_o),
        .core_mode_o   (core_mode_o),
        .core_opa_o    (core_opa_o),
        .core_opb_o    (core_opb_o),
        .core_opc_o    (core_opc_o),
        .core_tag_o    (core_tag_o),
        .core_valid_i  (core_valid_i),
        .core_ready_o  (core_ready_o),
        .core_result_i (core_result_i),
        .core_status_i (core_status_i),
        .core_tag_i    (core_tag_i),
        .flush_i       (flush_i),
        .idle_o        (idle_o)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic iq_fpu_req_t mk_req(input int wid);
        iq_fpu_req_t r;
        r      = '0;
        r.op   = 4'h3;
        r.mode = 1'b1;
        r.r0   = 32'h1000 + wid;
        r.r1   = 32'h2000 + wid;
        r.r2   = 32'h3000 + wid;
        r.wid  = rob_rid_t'(wid);
        return r;
    endfunction

    task automatic issue(input int wid, input int tag);
        ex_valid_i = 1'b1;
        ex_req_i   = mk_req(wid);
        #1;
        chk("req_rdy", ex_ready_o, 1);
        chk("req_cvld", core_valid_o, 1);
        chk("req_tag", core_tag_o, tag);
        chk("req_opa", core_opa_o, 32'h1000 + wid);
        chk("req_opc", core_opc_o, 32'h3000 + wid);
        step();
        ex_valid_i = 1'b0;
    endtask

    task automatic ret_push(input int tag, input logic [31:0] res,
                            input logic [4:0] st, input int wid);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'(tag);
        core_result_i = res;
        core_status_i = st;
        #1;
        chk("ret_rdy", core_ready_o, 1);
        step();
        core_valid_i = 1'b0;
        #1;
        chk("resp_vld", ex_valid_o, 1);
        chk("resp_wid", ex_resp_o.wid, wid);
        chk("resp_res", ex_resp_o.result, res);
        chk("resp_exc", ex_resp_o.fp_excp, st);
    endtask

    task automatic ret_kill(input int tag);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'(tag);
        core_result_i = 32'hdead0000 + tag;
        core_status_i = '0;
        #1;
        chk("kill_rdy", core_ready_o, 1);
        step();
        core_valid_i = 1'b0;
        #1;
        chk("kill_novld", ex_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        ex_valid_i    = 1'b1;
        ex_req_i      = mk_req(1);
        ex_ready_i    = 1'b1;
        core_ready_i  = 1'b1;
        core_valid_i  = 1'b0;
        core_result_i = '0;
        core_status_i = '0;
        core_tag_i    = '0;
        flush_i       = 1'b0;
        step();
        step();
        chk("rst_exvld", ex_valid_o, 0);
        chk("rst_exrdy", ex_ready_o, 0);
        chk("rst_cvld", core_valid_o, 0);
        chk("rst_crdy", core_ready_o, 1);
        chk("rst_idle", idle_o, 1);
        ex_valid_i = 1'b0;
        rst        = 1'b0;
        step();

        // out-of-order return
        issue(5, 0);
        issue(6, 1);
        issue(7, 2);
        chk("ooo_pre", ex_valid_o, 0);
        chk("ooo_busy", idle_o, 0);
        ret_push(2, 32'h3f800000, 5'b00001, 7);
        ret_push(0, 32'h40000000, 5'b10000, 5);
        ret_push(1, 32'h40400000, 5'b00000, 6);
        step();
        chk("ooo_empty", ex_valid_o, 0);
        chk("ooo_idle", idle_o, 1);

        // slot exhaustion, then free+request in the same cycle
        issue(10, 0);
        issue(11, 1);
        issue(12, 2);
        issue(13, 3);
        ex_valid_i    = 1'b1;
        ex_req_i      = mk_req(14);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'd1;
        core_result_i = 32'h11;
        core_status_i = '0;
        #1;
        chk("full_rdy", ex_ready_o, 0);
        chk("full_cvld", core_valid_o, 0);
        step();
        core_valid_i = 1'b0;
        #1;
        chk("realloc_rdy", ex_ready_o, 1);
        chk("realloc_tag", core_tag_o, 1);
        chk("realloc_resp", ex_resp_o.wid, 11);
        step();
        ex_valid_i = 1'b0;
        ret_push(0, 32'h10, 5'b0, 10);
        ret_push(2, 32'h12, 5'b0, 12);
        ret_push(3, 32'h13, 5'b0, 13);
        ret_push(1, 32'h14, 5'b0, 14);
        step();
        chk("exh_idle", idle_o, 1);

        // response backpressure
        ex_ready_i = 1'b0;
        issue(20, 0);
        issue(21, 1);
        issue(22, 2);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'd0;
        core_result_i = 32'haaaa;
        step();
        core_tag_i    = 2'd1;
        core_result_i = 32'hbbbb;
        #1;
        chk("bp_rdy1", core_ready_o, 1);
        step();
        core_tag_i    = 2'd2;
        core_result_i = 32'hcccc;
        #1;
        chk("bp_full", core_ready_o, 0);
        step();
        chk("bp_still", core_ready_o, 0);
        chk("bp_head0", ex_resp_o.wid, 20);
        ex_ready_i = 1'b1;
        step();
        ex_ready_i = 1'b0;
        #1;
        chk("bp_rdy2", core_ready_o, 1);
        chk("bp_head1", ex_resp_o.wid, 21);
        step();
        core_valid_i = 1'b0;
        ex_ready_i   = 1'b1;
        #1;
        chk("bp_head1b", ex_resp_o.result, 32'hbbbb);
        step();
        chk("bp_head2", ex_resp_o.wid, 22);
        chk("bp_res2", ex_resp_o.result, 32'hcccc);
        step();
        chk("bp_empty", ex_valid_o, 0);
        chk("bp_idle", idle_o, 1);

        // flush with in-flight ops and a queued response
        ex_ready_i = 1'b0;
        issue(30, 0);
        issue(31, 1);
        issue(32, 2);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'd2;
        core_result_i = 32'h3232;
        step();
        core_valid_i = 1'b0;
        #1;
        chk("fl_queued", ex_valid_o, 1);
        flush_i = 1'b1;
        #1;
        chk("fl_rdy", ex_ready_o, 0);
        step();
        flush_i = 1'b0;
        #1;
        chk("fl_cleared", ex_valid_o, 0);
        chk("fl_busy", idle_o, 0);
        ex_ready_i = 1'b1;
        ret_kill(0);
        ret_kill(1);
        chk("fl_idle", idle_o, 1);

        // flush coincident with request and return
        issue(40, 0);
        issue(41, 1);
        issue(42, 2);
        issue(43, 3);
        ex_valid_i    = 1'b1;
        ex_req_i      = mk_req(44);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'd3;
        core_result_i = 32'h4343;
        flush_i       = 1'b1;
        #1;
        chk("co_rdy", ex_ready_o, 0);
        chk("co_cvld", core_valid_o, 0);
        step();
        ex_valid_i   = 1'b0;
        core_valid_i = 1'b0;
        flush_i      = 1'b0;
        #1;
        chk("co_nopush", ex_valid_o, 0);
        ex_valid_i = 1'b1;
        #1;
        chk("co_free_rdy", ex_ready_o, 1);
        chk("co_free_tag", core_tag_o, 3);
        ex_valid_i = 1'b0;
        ret_kill(0);
        ret_kill(1);
        ret_kill(2);
        chk("co_idle", idle_o, 1);

        // async reset mid-operation
        ex_ready_i = 1'b0;
        issue(50, 0);
        issue(51, 1);
        issue(52, 2);
        issue(53, 3);
        core_valid_i  = 1'b1;
        core_tag_i    = 2'd1;
        core_result_i = 32'h5151;
        step();
        core_valid_i = 1'b0;
        #1;
        chk("ar_pre", ex_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("ar_vld", ex_valid_o, 0);
        chk("ar_idle", idle_o, 1);
        chk("ar_crdy", core_ready_o, 1);
        step();
        rst        = 1'b0;
        ex_ready_i = 1'b1;
        step();
        issue(60, 0);
        ret_push(0, 32'h6060, 5'b00100, 60);
        step();
        chk("ar_idle2", idle_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wired_fooo_ex.md
Name: wired_fooo_ex

Overview:
- FPU execution-side responder for the out-of-order FPU issue queue.
- Accepts `iq_fpu_req_t` requests over valid/ready and forwards them to the fpnew (cvfpu) core with a local slot tag.
- Keeps a slot table mapping tag -> ROB `wid`, so results return out of order in completion order.
- Buffers results in a small response FIFO that drives `iq_fpu_resp_t` back to the issue queue's CDB FIFO. Supports pipeline flush with in-flight kill.

Parameters:
- SLOTS, 4, max in-flight FPU ops (slot table depth).
- TAG_W, $clog2(SLOTS), core tag width.
- RESP_DEPTH, 2, response FIFO entries.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ex_valid_i  in  1  request valid from issue queue.
- ex_ready_o  out  1  request accepted.
- ex_req_i  in  $bits(iq_fpu_req_t)  op, mode, r0/r1/r2 (32b each), wid.
- ex_valid_o  out  1  response valid.
- ex_ready_i  in  1  response consumed.
- ex_resp_o  out  $bits(iq_fpu_resp_t)  wid, result (32b), fp_excp.
- core_valid_o  out  1  request to fpnew.
- core_ready_i  in  1  fpnew input ready.
- core_op_o  out  op width  ex_req_i.op passthrough.
- core_mode_o  out  mode width  ex_req_i.mode passthrough.
- core_opa_o, core_opb_o, core_opc_o  out  32 each  r0, r1, r2.
- core_tag_o  out  TAG_W  allocated slot index.
- core_valid_i  in  1  fpnew result valid.
- core_ready_o  out  1  result accepted.
- core_result_i  in  32  result.
- core_status_i  in  $bits(fp_excp_t)  exception flags.
- core_tag_i  in  TAG_W  returned slot index.
- flush_i  in  1  backend flush.
- idle_o  out  1  no busy slot and response FIFO empty.

Behaviour:
- State: per slot `busy`, `kill`, `wid`; response FIFO (rid, result, fp_excp) with count 0..RESP_DEPTH.
- Reset (async, rst=1): all busy/kill=0, FIFO empty. ex_valid_o=0, core_valid_o=0, core_ready_o=1, ex_ready_o=0, idle_o=1.
- Allocation: free = ~busy sampled at cycle start; the lowest-index free slot is chosen.
  - core_valid_o = ex_valid_i & |free & !flush_i.
  - ex_ready_o = |free & core_ready_i & !flush_i. This is a zero-latency combinational passthrough.
  - On fire (ex_valid_i & ex_ready_o): busy[sel] <= 1, kill[sel] <= 0, wid[sel] <= ex_req_i.wid, core_tag_o = sel.
- Return path:
  - core_ready_o = (count < RESP_DEPTH), registered from state only.
  - On core_valid_i & core_ready_o: busy[core_tag_i] <= 0.
  - If kill[core_tag_i]=0 and !flush_i, push {wid[core_tag_i], core_result_i, core_status_i}; otherwise discard silently.
- Latency: result accepted in cycle N appears on ex_valid_o in cycle N+1. FIFO output is registered and order is FIFO order of completion.
- FIFO: pop on ex_valid_o & ex_ready_i. Simultaneous push+pop when full is not possible (core_ready_o=0 when full). Push+pop otherwise keeps count.
- Simultaneous alloc and free in one cycle: the freed slot is not reallocated until the next cycle, since alloc uses start-of-cycle busy.
- Flush (flush_i=1, one or more cycles):
  - kill[i] <= busy[i] for all i; FIFO cleared to empty next cycle; ex_valid_o=0 next cycle.
  - No new request accepted in a flush cycle.
  - A core response arriving in the flush cycle frees its slot and is discarded.
  - Killed slots stay busy until fpnew returns their tag, then free without pushing. fpnew itself is never flushed.
- Protocol error: core_valid_i with a tag whose busy=0. The bench asserts on it; RTL ignores it (no push, no state change).
- idle_o = ~|busy & (count==0).
- Async reset mid-operation: all in-flight state lost immediately. fpnew is reset by the same rst.

Decomposition:
- Package (existing defines package): `iq_fpu_req_t`, `iq_fpu_resp_t`, `fp_excp_t`, `rob_rid_t`. Add localparam WIRED_FPU_SLOTS=4 and a `fpu_slot_t` struct {busy, kill, wid}.
- Response FIFO: reuse `wired_fifo`, with its active-low reset driven by !rst & !flush-registered.
- Optional sub-module `wired_fooo_slot_alloc`: lowest-free priority encoder plus busy/kill/wid table.

Test Plan:
- Out-of-order return:
  - Stimulus: issue wid 5,6,7 (tags 0,1,2); core returns tag 2, 0, 1 with results 0x3f800000, 0x40000000, 0x40400000.
  - Required: ex_resp_o wid order 7, 5, 6 with matching results, each one cycle after core accept.
- Slot exhaustion:
  - Stimulus: 4 requests accepted, no returns; a 5th request arrives.
  - Required: ex_ready_o=0 and core_valid_o=0. After tag 1 returns, the next request gets tag 1 one cycle later.
- Response backpressure:
  - Stimulus: ex_ready_i=0; three results returned.
  - Required: 2 enter the FIFO, core_ready_o=0 on the third. After one pop, the third is accepted and order is preserved.
- Flush with in-flight:
  - Stimulus: tags 0,1 busy, one FIFO entry pending; flush_i pulse; then core returns tags 0,1.
  - Required: FIFO empty, no ex_valid_o for the killed results, slots freed, idle_o=1 afterwards.
- Flush coincident with request and return:
  - Stimulus: ex_valid_i=1, core_valid_i=1 (tag 3), flush_i=1 in the same cycle.
  - Required: request not accepted, tag 3 freed, nothing pushed.
- Async reset:
  - Stimulus: assert rst mid-cycle with 3 busy slots and 1 queued response.
  - Required: immediately ex_valid_o=0, idle_o=1, core_ready_o=1; the next request after release gets tag 0.
